idu_stage: RTL and testbench
============================

Name: idu_stage

Overview:
- Registered, parametrised successor to the combinational decoder.
- Decodes RV32I/RV64I instructions, including immediate generation and a classified exception vector.
- Holds decoded bundles in a small FIFO with valid/ready handshakes on both sides and a pipeline flush.
- Sits between IFU and EXU. Decoding is combinational on entry; the result is stored per entry.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- XLEN, 64, datapath width; 32 or 64 only.
- RF_SIZE, 5, register index width.
- DEPTH, 2, buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  fetch bundle valid
- in_ready_o  out  1  stage can accept
- inst_i  in  INST_WIDTH  instruction
- pc_i  in  XLEN  instruction PC
- flush_i  in  1  discard all buffered entries
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  EXU accepts head
- out_pc_o  out  XLEN  head PC
- out_enable_o  out  5  {MWRITE,MREAD,RS2,RS1,RD}
- out_aluop_o  out  5  ALU opcode
- out_specinst_o  out  3  BR=0,JAL=1,JALR=2,AUIPC=3,LUI=4
- out_regi_o  out  3*RF_SIZE  {rs2,rs1,rd}
- out_detail_o  out  3  funct3
- out_imm_o  out  XLEN  sign-extended immediate
- out_exc_o  out  3  {illegal,ebreak,ecall}

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - count=0, read and write pointers=0.
  - out_valid_o=0, in_ready_o=1.
  - All out_* payloads become 0.
  - Reset mid-operation drops every entry.
- Handshakes:
  - Push when in_valid_i and in_ready_o are both high.
  - Pop when out_valid_o and out_ready_i are both high.
  - in_ready_o = (count != DEPTH). It is registered-state-only, with no combinational path from out_ready_i.
- Latency: a bundle pushed at edge N appears at out_* from cycle N+1 when the buffer was empty. Back-to-back throughput is one per cycle.
- Count update:
  - Simultaneous push and pop leaves count unchanged.
  - Push into a full buffer is impossible because ready is low.
  - Pop from an empty buffer is ignored.
- Pointers wrap modulo DEPTH.
- Flush:
  - flush_i clears count and both pointers at the edge.
  - It has priority over a same-cycle push, which is dropped, and over a same-cycle pop.
  - out_valid_o=0 the next cycle.
- Payload when out_valid_o=0: out_* hold the last head value; consumers must ignore them.
- ALU opcodes: ADD0 SUB1 OR2 AND3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 COPY_B10 ADDW11 SUBW12 SLLW13 SRLW14 SRAW15. The 5th bit is reserved for the optional feature.
- Enable and opcode mapping per opcode class is unchanged from the current decoder.
- Immediates are sign-extended from inst[31] to XLEN:
  - I-type: inst[31:20].
  - S-type: {31:25,11:7}.
  - B-type: {31,7,30:25,11:8,0}.
  - U-type: {31:12,12'b0}.
  - J-type: {31,19:12,20,30:21,0}.
  - R-type: 0.
- Shift immediate shamt: inst[25:20] when XLEN=64, inst[24:20] when XLEN=32.
- out_exc_o[2] (illegal) is set on any of:
  - Unknown opcode.
  - Load funct3=111.
  - Store funct3 >= 100.
  - Branch funct3 010 or 011.
  - OP funct7 not in {0000000, 0100000}, or 0100000 with funct3 other than 000/101.
  - Env with funct3!=0, or funct12 not in {0,1}.
  - XLEN=32 and any of: opcode 0x1b/0x3b; LD (011); LWU (110); SD (011); slli/srli/srai with inst[25]=1.
- Illegal entries are still buffered, with enables forced to 0.
- out_exc_o[0]=1 for ecall (funct12=0); out_exc_o[1]=1 for ebreak (funct12=1). At most one bit of out_exc_o is set.

Optional Feature:
- IDU_MEXT_EN defined:
  - OP and OP-32 with funct7=0000001 decode as M-extension.
  - Aluop = 16 + funct3: MUL16 MULH17 MULHSU18 MULHU19 DIV20 DIVU21 REM22 REMU23.
  - W-forms (OP-32): MULW24 DIVW25 DIVUW26 REMW27 REMUW28. OP-32 funct3 001/010/011 with funct7=0000001 is illegal.
  - Enables are RD|RS1|RS2.
- IDU_MEXT_EN undefined: funct7=0000001 is illegal, and aluop never exceeds 15.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5), pc=0x80000000 → next cycle: out_valid=1, enable=00011, aluop=0, imm=5, regi rd=1, rs1=0, exc=000.
- Push 0x402081b3 (sub x3,x1,x2) → aluop=1, enable=00111, imm=0. Then push 0xfe000ee3 (beq x0,x0,-4) → aluop=1, specinst=0, imm=0xFFFF_FFFF_FFFF_FFFC.
- DEPTH=2, out_ready=0, push three bundles → in_ready low after the 2nd accept. 3rd held until one pop. Entries emerge in order without loss.
- Buffer holding 2 entries, flush_i=1 with simultaneous push of a 3rd → next cycle out_valid=0, count=0, pushed bundle absent.
- Push 0x00000073 → exc=001; 0x00100073 → exc=010; 0x00000000 → exc=100 with enable=0.
- Push 0x023100b3 (mul) → aluop=16 with IDU_MEXT_EN, exc=100 without. XLEN=32: push 0x003100bb (addw) → exc=100.

Source files
------------

// File: rtl/idu_stage.sv
// idu_stage: registered RV32I/RV64I decoder feeding a DEPTH-entry bundle FIFO.
// Optional macro IDU_MEXT_EN adds M-extension decode (aluop 16..28).
module idu_stage #(
  parameter int INST_WIDTH = 32,
  parameter int XLEN       = 64,
  parameter int RF_SIZE    = 5,
  parameter int DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INST_WIDTH-1:0]  inst_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [4:0]             out_enable_o,
  output logic [4:0]             out_aluop_o,
  output logic [2:0]             out_specinst_o,
  output logic [3*RF_SIZE-1:0]   out_regi_o,
  output logic [2:0]             out_detail_o,
  output logic [XLEN-1:0]        out_imm_o,
  output logic [2:0]             out_exc_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit RV64 = (XLEN == 64);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_OR    = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_COPYB = 5'd10;
  localparam logic [4:0] ALU_ADDW  = 5'd11;
  localparam logic [4:0] ALU_SUBW  = 5'd12;
  localparam logic [4:0] ALU_SLLW  = 5'd13;
  localparam logic [4:0] ALU_SRLW  = 5'd14;
  localparam logic [4:0] ALU_SRAW  = 5'd15;

  localparam logic [2:0] SP_BR    = 3'd0;
  localparam logic [2:0] SP_JAL   = 3'd1;
  localparam logic [2:0] SP_JALR  = 3'd2;
  localparam logic [2:0] SP_AUIPC = 3'd3;
  localparam logic [2:0] SP_LUI   = 3'd4;

  // {MWRITE,MREAD,RS2,RS1,RD}
  localparam logic [4:0] EN_RD = 5'b00001;
  localparam logic [4:0] EN_I  = 5'b00011;
  localparam logic [4:0] EN_R  = 5'b00111;
  localparam logic [4:0] EN_B  = 5'b00110;
  localparam logic [4:0] EN_S  = 5'b10110;
  localparam logic [4:0] EN_L  = 5'b01011;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [4:0]           en;
    logic [4:0]           alu;
    logic [2:0]           spec;
    logic [3*RF_SIZE-1:0] regi;
    logic [2:0]           f3;
    logic [XLEN-1:0]      imm;
    logic [2:0]           exc;
  } id_ex_t;

  function automatic logic [4:0] alu_f3(
    input logic [2:0] f,
    input logic       alt
  );
    logic [4:0] r;
    case (f)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign ins = inst_i[31:0];
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt, shamt5;
  assign imm_i  = XLEN'($signed(ins[31:20]));
  assign imm_s  = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b  = XLEN'($signed({ins[31], ins[7], ins[30:25],
                                 ins[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({ins[31], ins[19:12], ins[20],
                                 ins[30:21], 1'b0}));
  assign shamt  = RV64 ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
  assign shamt5 = XLEN'(ins[24:20]);

  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
  logic is_opi, is_opi32, is_op, is_op32, is_fence, is_sys;
  assign is_lui   = (opc == 7'h37);
  assign is_auipc = (opc == 7'h17);
  assign is_jal   = (opc == 7'h6f);
  assign is_jalr  = (opc == 7'h67);
  assign is_br    = (opc == 7'h63);
  assign is_ld    = (opc == 7'h03);
  assign is_st    = (opc == 7'h23);
  assign is_opi   = (opc == 7'h13);
  assign is_opi32 = (opc == 7'h1b);
  assign is_op    = (opc == 7'h33);
  assign is_op32  = (opc == 7'h3b);
  assign is_fence = (opc == 7'h0f);
  assign is_sys   = (opc == 7'h73);

  logic [4:0]      en, alu;
  logic [2:0]      spec;
  logic [XLEN-1:0] imm;
  logic            ill, ecall, ebreak;

  always_comb begin
    en     = '0;
    alu    = ALU_ADD;
    spec   = SP_BR;
    imm    = '0;
    ill    = 1'b0;
    ecall  = 1'b0;
    ebreak = 1'b0;
    unique case (1'b1)
      is_lui: begin
        en = EN_RD; alu = ALU_COPYB;
        spec = SP_LUI; imm = imm_u;
      end
      is_auipc: begin
        en = EN_RD; spec = SP_AUIPC; imm = imm_u;
      end
      is_jal: begin
        en = EN_RD; spec = SP_JAL; imm = imm_j;
      end
      is_jalr: begin
        en = EN_I; spec = SP_JALR; imm = imm_i;
      end
      is_br: begin
        en  = EN_B;
        imm = imm_b;
        alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      is_ld: begin
        en = EN_L; imm = imm_i;
        if (f3 == 3'b111) ill = 1'b1;
        if (!RV64 && (f3 == 3'b011 || f3 == 3'b110)) ill = 1'b1;
      end
      is_st: begin
        en = EN_S; imm = imm_s;
        if (f3[2]) ill = 1'b1;
        if (!RV64 && f3 == 3'b011) ill = 1'b1;
      end
      is_opi: begin
        en  = EN_I;
        alu = alu_f3(f3, (f3 == 3'b101) && ins[30]);
        imm = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm = shamt;
          if (!RV64 && ins[25]) ill = 1'b1;
        end
      end
      is_opi32: begin
        en  = EN_I;
        ill = !RV64;
        unique case (f3)
          3'b000: begin alu = ALU_ADDW; imm = imm_i; end
          3'b001: begin alu = ALU_SLLW; imm = shamt5; end
          3'b101: begin
            alu = ins[30] ? ALU_SRAW : ALU_SRLW;
            imm = shamt5;
          end
          default: ill = 1'b1;
        endcase
      end
      is_op: begin
        en = EN_R;
        unique case (f7)
          7'b0000000: alu = alu_f3(f3, 1'b0);
          7'b0100000: begin
            alu = alu_f3(f3, 1'b1);
            if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
          end
`ifdef IDU_MEXT_EN
          7'b0000001: alu = 5'd16 + {2'b00, f3};
`endif
          default: ill = 1'b1;
        endcase
      end
      is_op32: begin
        en  = EN_R;
        ill = !RV64;
        unique case (f7)
          7'b0000000: begin
            unique case (f3)
              3'b000:  alu = ALU_ADDW;
              3'b001:  alu = ALU_SLLW;
              3'b101:  alu = ALU_SRLW;
              default: ill = 1'b1;
            endcase
          end
          7'b0100000: begin
            unique case (f3)
              3'b000:  alu = ALU_SUBW;
              3'b101:  alu = ALU_SRAW;
              default: ill = 1'b1;
            endcase
          end
`ifdef IDU_MEXT_EN
          7'b0000001: begin
            unique case (f3)
              3'b000:  alu = 5'd24;
              3'b100:  alu = 5'd25;
              3'b101:  alu = 5'd26;
              3'b110:  alu = 5'd27;
              3'b111:  alu = 5'd28;
              default: ill = 1'b1;
            endcase
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      is_fence: en = '0;
      is_sys: begin
        ill    = (f3 != 3'b000) || (ins[31:21] != '0);
        ecall  = !ill && !ins[20];
        ebreak = !ill && ins[20];
      end
      default: ill = 1'b1;
    endcase
  end

  id_ex_t dec;
  always_comb begin
    dec      = '0;
    dec.pc   = pc_i;
    dec.en   = ill ? 5'b0 : en;
    dec.alu  = alu;
    dec.spec = spec;
    dec.regi = {RF_SIZE'(ins[24:20]), RF_SIZE'(ins[19:15]),
                RF_SIZE'(ins[11:7])};
    dec.f3   = f3;
    dec.imm  = imm;
    dec.exc  = ill ? 3'b100 : {1'b0, ebreak, ecall};
  end

  id_ex_t          mem [DEPTH];
  id_ex_t          hold_q;
  id_ex_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;

  assign in_ready_o  = (count != FULL);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // hold_q keeps the last head so payloads stay stable while empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      if (out_valid_o) hold_q <= mem[rd_ptr];
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign head           = out_valid_o ? mem[rd_ptr] : hold_q;
  assign out_pc_o       = head.pc;
  assign out_enable_o   = head.en;
  assign out_aluop_o    = head.alu;
  assign out_specinst_o = head.spec;
  assign out_regi_o     = head.regi;
  assign out_detail_o   = head.f3;
  assign out_imm_o      = head.imm;
  assign out_exc_o      = head.exc;

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: scoreboard bench for idu_stage (RV64 instance plus an
// RV32 instance for the XLEN=32 illegal-encoding cases).
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;
  logic        flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_en, out_alu;
  logic [2:0]  out_spec, out_det, out_exc;
  logic [14:0] out_regi;

  idu_stage #(.INST_WIDTH(32), .XLEN(64), .RF_SIZE(5), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_enable_o(out_en), .out_aluop_o(out_alu),
    .out_specinst_o(out_spec), .out_regi_o(out_regi),
    .out_detail_o(out_det), .out_imm_o(out_imm), .out_exc_o(out_exc)
  );

  logic        b_in_valid = 1'b0, b_in_ready;
  logic [31:0] b_inst = '0, b_pc = '0;
  logic        b_out_valid;
  logic [31:0] b_out_pc, b_out_imm;
  logic [4:0]  b_out_en, b_out_alu;
  logic [2:0]  b_out_spec, b_out_det, b_out_exc;
  logic [14:0] b_out_regi;

  idu_stage #(.INST_WIDTH(32), .XLEN(32), .RF_SIZE(5), .DEPTH(2)) u_rv32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .inst_i(b_inst), .pc_i(b_pc), .flush_i(1'b0),
    .out_valid_o(b_out_valid), .out_ready_i(1'b1),
    .out_pc_o(b_out_pc), .out_enable_o(b_out_en), .out_aluop_o(b_out_alu),
    .out_specinst_o(b_out_spec), .out_regi_o(b_out_regi),
    .out_detail_o(b_out_det), .out_imm_o(b_out_imm), .out_exc_o(b_out_exc)
  );

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  en;
    logic [4:0]  alu;
    logic [2:0]  spec;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  exc;
    bit          full;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] en, input logic [4:0] alu,
                              input logic [2:0] sp, input logic [63:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [2:0] exc, input bit full);
    exp_t e;
    e.pc = '0; e.en = en; e.alu = alu; e.spec = sp; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.exc = exc; e.full = full;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pc", out_pc, e.pc);
        chk("enable", 64'(out_en), 64'(e.en));
        chk("exc", 64'(out_exc), 64'(e.exc));
        if (e.full) begin
          chk("aluop", 64'(out_alu), 64'(e.alu));
          chk("specinst", 64'(out_spec), 64'(e.spec));
          chk("imm", out_imm, e.imm);
          chk("rd", 64'(out_regi[4:0]), 64'(e.rd));
          chk("rs1", 64'(out_regi[9:5]), 64'(e.rs1));
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [63:0] p,
                      input exp_t e);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    inst     = ins;
    pc       = p;
    e.pc     = p;
    t        = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) chk("send_tmo", 64'(in_ready), 64'd1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic send32(input logic [31:0] ins, input logic [2:0] exc,
                        input logic [4:0] en);
    @(posedge clk);
    #1;
    b_in_valid = 1'b1;
    b_inst     = ins;
    b_pc       = 32'h100;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("rv32_valid", 64'(b_out_valid), 64'd1);
    chk("rv32_exc", 64'(b_out_exc), 64'(exc));
    chk("rv32_en", 64'(b_out_en), 64'(en));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_rv32_valid", 64'(b_out_valid), 64'd0);

    // latency: one cycle from push into an empty buffer
    out_ready = 1'b1;
    send(32'h00500093, 64'h8000_0000, mk(5'b00011, 5'd0, 3'd0, 64'd5,
         5'd1, 5'd0, 3'b000, 1));
    chk("lat_valid", 64'(out_valid), 64'd1);
    drain();

    send(32'h402081b3, 64'h8000_0004, mk(5'b00111, 5'd1, 3'd0, 64'd0,
         5'd3, 5'd1, 3'b000, 1));
    send(32'hfe000ee3, 64'h8000_0008, mk(5'b00110, 5'd1, 3'd0,
         64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 5'd0, 3'b000, 1));
    send(32'hfff08113, 64'h8000_000c, mk(5'b00011, 5'd0, 3'd0,
         64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 5'd1, 3'b000, 1));
    send(32'h43f0d093, 64'h8000_0010, mk(5'b00011, 5'd7, 3'd0, 64'd63,
         5'd1, 5'd1, 3'b000, 1));
    send(32'h123450b7, 64'h8000_0014, mk(5'b00001, 5'd10, 3'd4,
         64'h1234_5000, 5'd1, 5'd8, 3'b000, 1));
    send(32'h008000ef, 64'h8000_0018, mk(5'b00001, 5'd0, 3'd1, 64'd8,
         5'd1, 5'd0, 3'b000, 1));
    send(32'h0020a223, 64'h8000_001c, mk(5'b10110, 5'd0, 3'd0, 64'd4,
         5'd4, 5'd1, 3'b000, 1));
    send(32'h0000b083, 64'h8000_0020, mk(5'b01011, 5'd0, 3'd0, 64'd0,
         5'd1, 5'd1, 3'b000, 1));
    send(32'h00000073, 64'h8000_0024, mk(5'b00000, 5'd0, 3'd0, 64'd0,
         5'd0, 5'd0, 3'b001, 1));
    send(32'h00100073, 64'h8000_0028, mk(5'b00000, 5'd0, 3'd0, 64'd0,
         5'd0, 5'd0, 3'b010, 1));
    send(32'h00000000, 64'h8000_002c, mk(5'b00000, 5'd0, 3'd0, 64'd0,
         5'd0, 5'd0, 3'b100, 0));
`ifdef IDU_MEXT_EN
    send(32'h023100b3, 64'h8000_0030, mk(5'b00111, 5'd16, 3'd0, 64'd0,
         5'd1, 5'd2, 3'b000, 1));
`else
    send(32'h023100b3, 64'h8000_0030, mk(5'b00000, 5'd0, 3'd0, 64'd0,
         5'd0, 5'd0, 3'b100, 0));
`endif
    drain();

    // fill to DEPTH with consumer stalled; third push must wait
    out_ready = 1'b0;
    send(32'h00100093, 64'h9000_0000, mk(5'b00011, 5'd0, 3'd0, 64'd1,
         5'd1, 5'd0, 3'b000, 1));
    send(32'h00200093, 64'h9000_0004, mk(5'b00011, 5'd0, 3'd0, 64'd2,
         5'd1, 5'd0, 3'b000, 1));
    fork
      send(32'h00300093, 64'h9000_0008, mk(5'b00011, 5'd0, 3'd0, 64'd3,
           5'd1, 5'd0, 3'b000, 1));
      begin
        repeat (3) @(negedge clk);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // flush a full buffer while a push is offered
    out_ready = 1'b0;
    send(32'h00100093, 64'hA000_0000, mk(5'b00011, 5'd0, 3'd0, 64'd1,
         5'd1, 5'd0, 3'b000, 1));
    send(32'h00200093, 64'hA000_0004, mk(5'b00011, 5'd0, 3'd0, 64'd2,
         5'd1, 5'd0, 3'b000, 1));
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; inst = 32'h00300093; pc = 64'hA000_0008;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_hold_pc", out_pc, 64'hA000_0000);

    // flush with space available: the same-cycle push is dropped
    send(32'h00400093, 64'hB000_0000, mk(5'b00011, 5'd0, 3'd0, 64'd4,
         5'd1, 5'd0, 3'b000, 1));
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 64'hB000_0004;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_push_drop", 64'(out_valid), 64'd0);

    // reset mid-operation drops buffered entries
    out_ready = 1'b0;
    send(32'h00600093, 64'hC000_0000, mk(5'b00011, 5'd0, 3'd0, 64'd6,
         5'd1, 5'd0, 3'b000, 1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pc", out_pc, 64'd0);

    // RV32 instance: RV64-only encodings are illegal
    send32(32'h00500093, 3'b000, 5'b00011);
    chk("rv32_imm", 64'(b_out_imm), 64'd5);
    send32(32'h003100bb, 3'b100, 5'b00000);
    send32(32'h0000b083, 3'b100, 5'b00000);
    send32(32'h0230d093, 3'b100, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
